// File: rtl/sll_iter.sv
// sll_iter: iterative logical-left shifter.
// One barrel stage (shift by 1, 2, 4, ... 2**(SHAMT_W-1)) is applied per clock,
// each gated by the matching bit of the latched shift amount. A start/ready
// handshake lets the ALU wrapper issue shifts without a wide combinational barrel.
// Latency is fixed at SHAMT_W compute cycles plus one RDY cycle.
module sll_iter #(
  parameter int WIDTH   = 32,  // data width, expected to equal 2**SHAMT_W
  parameter int SHAMT_W = 5    // shift-amount width = number of stages
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ctrl_start,
  input  logic [WIDTH-1:0]   data_operandA,
  input  logic [SHAMT_W-1:0] ctrl_shiftamt,
  output logic [WIDTH-1:0]   data_result,
  output logic               data_resultRDY,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Counter only needs to index the stages 0..SHAMT_W-1.
  localparam int CNT_W = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;
  localparam logic [CNT_W-1:0] LAST_STAGE = CNT_W'(SHAMT_W - 1);

  state_t               state_reg;
  state_t               state_next;
  logic [CNT_W-1:0]     cnt_reg;
  logic [WIDTH-1:0]     work_reg;
  logic [SHAMT_W-1:0]   sh_reg;
  logic [WIDTH-1:0]     result_reg;

  logic [WIDTH-1:0]     stage_out [SHAMT_W];
  logic [WIDTH-1:0]     stage_sel;
  logic                 capture;
  logic                 last_stage;

  // Candidate output of every stage; only the one selected by cnt_reg is used
  // in a given cycle, so the logic per cycle is a single shift-by-constant.
  generate
    for (genvar gi = 0; gi < SHAMT_W; gi++) begin : g_stage
      assign stage_out[gi] = sh_reg[gi] ? (work_reg << (2 ** gi)) : work_reg;
    end
  endgenerate

  // Pick the stage output for the current compute cycle.
  always_comb begin
    stage_sel = work_reg;
    for (int i = 0; i < SHAMT_W; i++) begin
      if (cnt_reg == CNT_W'(i)) begin
        stage_sel = stage_out[i];
      end
    end
  end

  assign last_stage = (cnt_reg == LAST_STAGE);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and handshake outputs; a new operation may be accepted
  // in IDLE or in the single DONE cycle (back-to-back issue).
  always_comb begin
    state_next     = state_reg;
    capture        = 1'b0;
    busy           = 1'b0;
    data_resultRDY = 1'b0;
    case (state_reg)
      IDLE: begin
        if (ctrl_start) begin
          capture    = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_stage) begin
          state_next = DONE;
        end
      end
      DONE: begin
        data_resultRDY = 1'b1;
        if (ctrl_start) begin
          capture    = 1'b1;
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: capture operands, walk the stages, publish the final value once.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_reg    <= '0;
      work_reg   <= '0;
      sh_reg     <= '0;
      result_reg <= '0;
    end else if (capture) begin
      work_reg <= data_operandA;
      sh_reg   <= ctrl_shiftamt;
      cnt_reg  <= '0;
    end else if (state_reg == SHIFT) begin
      work_reg <= stage_sel;
      cnt_reg  <= cnt_reg + 1'b1;
      if (last_stage) begin
        result_reg <= stage_sel;
      end
    end
  end

  assign data_result = result_reg;

endmodule

// File: tb/tb_sll_iter.sv
// Directed testbench for sll_iter: fixed-latency handshake, stage gating,
// zero fill, input isolation, back-to-back issue and mid-operation reset.
module tb_sll_iter;

  logic        clock;
  logic        reset;
  logic        ctrl_start;
  logic [31:0] data_operandA;
  logic [4:0]  ctrl_shiftamt;
  logic [31:0] data_result;
  logic        data_resultRDY;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  sll_iter #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_start     (ctrl_start),
    .data_operandA  (data_operandA),
    .ctrl_shiftamt  (ctrl_shiftamt),
    .data_result    (data_result),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present an operation and let edge E0 capture it.
  task automatic issue(input logic [31:0] a, input logic [4:0] s);
    ctrl_start    = 1'b1;
    data_operandA = a;
    ctrl_shiftamt = s;
    step();
    ctrl_start    = 1'b0;
    data_operandA = 32'h0;
    ctrl_shiftamt = 5'd0;
  endtask

  // From just after E0, walk edges E1..E5 and stop inside the RDY cycle.
  task automatic expect_op(input string tag, input logic [31:0] exp, input logic [31:0] prev);
    for (int k = 1; k <= 5; k++) begin
      check($sformatf("%s busy before E%0d", tag, k), {31'b0, busy}, 32'd1);
      check($sformatf("%s rdy before E%0d", tag, k), {31'b0, data_resultRDY}, 32'd0);
      check($sformatf("%s hold before E%0d", tag, k), data_result, prev);
      step();
    end
    check($sformatf("%s rdy", tag), {31'b0, data_resultRDY}, 32'd1);
    check($sformatf("%s busy in rdy", tag), {31'b0, busy}, 32'd0);
    check($sformatf("%s result", tag), data_result, exp);
  endtask

  // One more edge with no start: RDY must drop, result must hold.
  task automatic expect_idle(input string tag, input logic [31:0] exp);
    step();
    check($sformatf("%s rdy after", tag), {31'b0, data_resultRDY}, 32'd0);
    check($sformatf("%s busy after", tag), {31'b0, busy}, 32'd0);
    check($sformatf("%s result after", tag), data_result, exp);
  endtask

  initial begin
    int rdy_count;
    reset         = 1'b1;
    ctrl_start    = 1'b1;  // reset must win over a simultaneous start
    data_operandA = 32'hFFFF_FFFF;
    ctrl_shiftamt = 5'd3;
    step();
    step();
    check("reset result", data_result, 32'h0);
    check("reset rdy", {31'b0, data_resultRDY}, 32'd0);
    check("reset busy", {31'b0, busy}, 32'd0);
    reset         = 1'b0;
    ctrl_start    = 1'b0;
    step();
    check("idle busy", {31'b0, busy}, 32'd0);

    // Basic: 1 << 31
    issue(32'h0000_0001, 5'd31);
    expect_op("basic", 32'h8000_0000, 32'h0);
    expect_idle("basic", 32'h8000_0000);

    // Zero fill and shamt=0 with unchanged latency
    issue(32'hFFFF_FFFF, 5'd4);
    expect_op("zfill", 32'hFFFF_FFF0, 32'h8000_0000);
    expect_idle("zfill", 32'hFFFF_FFF0);
    issue(32'h8765_4321, 5'd0);
    expect_op("sh0", 32'h8765_4321, 32'hFFFF_FFF0);
    expect_idle("sh0", 32'h8765_4321);

    // Mixed stages 1, 4, 8
    issue(32'h1234_5678, 5'd13);
    expect_op("mixed", 32'h8ACF_0000, 32'h8765_4321);
    expect_idle("mixed", 32'h8ACF_0000);

    // Input isolation: a second start at E2 is ignored
    issue(32'h0000_00FF, 5'd8);
    step();  // E1
    ctrl_start    = 1'b1;
    data_operandA = 32'hDEAD_BEEF;
    ctrl_shiftamt = 5'd1;
    step();  // E2
    ctrl_start    = 1'b0;
    check("iso busy after E2", {31'b0, busy}, 32'd1);
    check("iso hold after E2", data_result, 32'h8ACF_0000);
    data_operandA = 32'h1111_1111;
    ctrl_shiftamt = 5'd7;
    step();  // E3
    step();  // E4
    step();  // E5
    check("iso rdy", {31'b0, data_resultRDY}, 32'd1);
    check("iso result", data_result, 32'h0000_FF00);
    rdy_count = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (data_resultRDY) rdy_count++;
    end
    check("iso extra rdy pulses", rdy_count, 0);
    check("iso result held", data_result, 32'h0000_FF00);

    // Back-to-back: new start held in the DONE cycle
    issue(32'h0000_0001, 5'd2);
    expect_op("b2b first", 32'h0000_0004, 32'h0000_FF00);
    issue(32'h0000_0003, 5'd1);
    check("b2b rdy dropped", {31'b0, data_resultRDY}, 32'd0);
    expect_op("b2b second", 32'h0000_0006, 32'h0000_0004);
    expect_idle("b2b second", 32'h0000_0006);

    // Reset mid-operation at E3
    issue(32'h0000_000F, 5'd2);
    step();  // E1
    step();  // E2
    reset = 1'b1;
    step();  // E3 sampled with reset
    reset = 1'b0;
    check("midrst result", data_result, 32'h0);
    check("midrst busy", {31'b0, busy}, 32'd0);
    check("midrst rdy", {31'b0, data_resultRDY}, 32'd0);
    rdy_count = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (data_resultRDY || busy) rdy_count++;
    end
    check("midrst stays idle", rdy_count, 0);
    issue(32'h0000_000F, 5'd2);
    expect_op("post rst", 32'h0000_003C, 32'h0);
    expect_idle("post rst", 32'h0000_003C);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
